// File: rtl/sid_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sid_pkg
// Description : Shared widths, types and sample-format helper for the SID
//               audio output path (mos6581 -> sid_i2s_tx).
// Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
// Contents    : SID_SAMPLE_W   - width of one mixed SID sample
//               I2S_FRAME_BITS - BCLK periods per stereo I2S frame
//               I2S_SLOT_BITS  - BCLK periods per left/right slot
//               sid_sample_t, i2s_bit_idx_t, sid_to_twos()
// ============================================================================
package sid_pkg;

    localparam int SID_SAMPLE_W   = 16;
    localparam int I2S_FRAME_BITS = 32;
    localparam int I2S_SLOT_BITS  = 16;

    typedef logic [SID_SAMPLE_W-1:0]            sid_sample_t;
    typedef logic [$clog2(I2S_FRAME_BITS)-1:0]  i2s_bit_idx_t;

    // Offset-binary and two's complement differ only in the sign bit.
    function automatic sid_sample_t sid_to_twos(input sid_sample_t x,
                                                input logic        offset_bin);
        return {x[SID_SAMPLE_W-1] ^ offset_bin, x[SID_SAMPLE_W-2:0]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/sid_clkdiv.sv
`default_nettype none
// ============================================================================
// Module      : sid_clkdiv
// Description : Bit-clock generator. Toggles bclk every DIV clk cycles and
//               flags the clk cycle in which each toggle happens.
// Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports       : clk      in  system clock
//               n_reset  in  asynchronous active-low reset
//               bclk     out bit clock (registered), period 2*DIV clk
//               rise     out high in the cycle where bclk goes 0->1
//               fall     out high in the cycle where bclk goes 1->0
// ============================================================================
module sid_clkdiv #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic n_reset,
    output logic bclk,
    output logic rise,
    output logic fall
);

    localparam int c_CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DIV - 1);

    logic [c_CNT_W-1:0] r_div_cnt;
    logic               r_bclk;
    logic               w_tick;

    assign w_tick = (r_div_cnt == c_CNT_LAST);

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_div_cnt <= '0;
            r_bclk    <= 1'b0;
        end else if (w_tick) begin
            r_div_cnt <= '0;
            r_bclk    <= ~r_bclk;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    // Strobes mark the cycle whose clock edge performs the toggle, so logic
    // clocked on that edge updates together with bclk.
    assign bclk = r_bclk;
    assign rise = w_tick & ~r_bclk;
    assign fall = w_tick &  r_bclk;

endmodule
`default_nettype wire

// File: rtl/sid_i2s_tx.sv
`default_nettype none
// ============================================================================
// Module      : sid_i2s_tx
// Description : Philips I2S transmitter for the 16-bit SID mix. Holds one
//               pending sample and sends it mono-duplicated in both slots.
// Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports       : clk          in  system clock
//               n_reset      in  asynchronous active-low reset
//               audio_in     in  [15:0] sample from mos6581 audio_out
//               sample_stb   in  one-clk pulse, captures audio_in
//               i2s_bclk     out bit clock
//               i2s_lrclk    out word select, 0 = left, 1 = right
//               i2s_sdata    out serial data, MSB first, changes on BCLK fall
//               frame_start  out one-clk pulse when a new word is loaded
//               underrun     out one-clk pulse, frame started without fresh data
//               overrun      out one-clk pulse, pending sample overwritten
// ============================================================================
module sid_i2s_tx
    import sid_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int OFFSET_BIN = 1
) (
    input  logic                    clk,
    input  logic                    n_reset,
    input  logic [SID_SAMPLE_W-1:0] audio_in,
    input  logic                    sample_stb,
    output logic                    i2s_bclk,
    output logic                    i2s_lrclk,
    output logic                    i2s_sdata,
    output logic                    frame_start,
    output logic                    underrun,
    output logic                    overrun
);

    localparam i2s_bit_idx_t c_LAST_BIT  = i2s_bit_idx_t'(I2S_FRAME_BITS - 1);
    localparam i2s_bit_idx_t c_RIGHT_LR  = i2s_bit_idx_t'(I2S_SLOT_BITS - 1);
    localparam logic         c_OFFSET_EN = (OFFSET_BIN != 0);

    logic         w_bclk_fall;
    logic         w_unused_rise;

    i2s_bit_idx_t r_bit_cnt;
    sid_sample_t  r_pending;
    logic         r_pending_valid;
    sid_sample_t  r_tx_word;
    logic         r_sdata;
    logic         r_lrclk;
    logic         r_frame_start;
    logic         r_underrun;
    logic         r_overrun;

    logic         w_load;
    i2s_bit_idx_t w_bit_next;
    sid_sample_t  w_word_next;

    sid_clkdiv #(
        .DIV (CLK_DIV)
    ) u_clkdiv (
        .clk     (clk),
        .n_reset (n_reset),
        .bclk    (i2s_bclk),
        .rise    (w_unused_rise),
        .fall    (w_bclk_fall)
    );

    assign w_load     = w_bclk_fall && (r_bit_cnt == c_LAST_BIT);
    assign w_bit_next = r_bit_cnt + 1'b1;
    // On a load without fresh data the previous word is repeated.
    assign w_word_next = (w_load && r_pending_valid)
                       ? sid_to_twos(r_pending, c_OFFSET_EN)
                       : r_tx_word;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_bit_cnt       <= c_LAST_BIT;
            r_pending       <= '0;
            r_pending_valid <= 1'b0;
            r_tx_word       <= '0;
            r_sdata         <= 1'b0;
            r_lrclk         <= 1'b0;
            r_frame_start   <= 1'b0;
            r_underrun      <= 1'b0;
            r_overrun       <= 1'b0;
        end else begin
            r_frame_start <= w_load;
            r_underrun    <= w_load && !r_pending_valid;
            // A strobe coinciding with a load refills the slot just emptied,
            // so it is not an overrun.
            r_overrun     <= sample_stb && r_pending_valid && !w_load;

            if (sample_stb) begin
                r_pending       <= audio_in;
                r_pending_valid <= 1'b1;
            end else if (w_load) begin
                r_pending_valid <= 1'b0;
            end

            if (w_bclk_fall) begin
                r_bit_cnt <= w_bit_next;
                r_tx_word <= w_word_next;
                // Both slots carry the same word: bit position within the slot
                // is the low four bits of the count, MSB first (~n == 15-n).
                r_sdata   <= w_word_next[~w_bit_next[3:0]];
                // WS leads each slot's MSB by one BCLK.
                r_lrclk   <= (w_bit_next >= c_RIGHT_LR) && (w_bit_next != c_LAST_BIT);
            end
        end
    end

    assign i2s_lrclk   = r_lrclk;
    assign i2s_sdata   = r_sdata;
    assign frame_start = r_frame_start;
    assign underrun    = r_underrun;
    assign overrun     = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_sid_i2s_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_sid_i2s_tx
// Description : Self-checking bench for sid_i2s_tx. Three instances share the
//               stimulus: [0] CLK_DIV=4/OFFSET_BIN=0, [1] CLK_DIV=4/
//               OFFSET_BIN=1, [2] CLK_DIV=1/OFFSET_BIN=1. A time-based
//               reference model predicts every output of every instance.
// Revision    : 1.0  initial release
// ============================================================================
module tb_sid_i2s_tx;

    logic        clk        = 1'b0;
    logic        n_reset    = 1'b1;
    logic [15:0] audio_in   = '0;
    logic        sample_stb = 1'b0;

    logic [2:0] bclk, lrclk, sdata, fstart, urun, orun;

    always #5 clk = ~clk;

    sid_i2s_tx #(.CLK_DIV(4), .OFFSET_BIN(0)) u_dut0 (
        .clk(clk), .n_reset(n_reset), .audio_in(audio_in), .sample_stb(sample_stb),
        .i2s_bclk(bclk[0]), .i2s_lrclk(lrclk[0]), .i2s_sdata(sdata[0]),
        .frame_start(fstart[0]), .underrun(urun[0]), .overrun(orun[0]));

    sid_i2s_tx #(.CLK_DIV(4), .OFFSET_BIN(1)) u_dut1 (
        .clk(clk), .n_reset(n_reset), .audio_in(audio_in), .sample_stb(sample_stb),
        .i2s_bclk(bclk[1]), .i2s_lrclk(lrclk[1]), .i2s_sdata(sdata[1]),
        .frame_start(fstart[1]), .underrun(urun[1]), .overrun(orun[1]));

    sid_i2s_tx #(.CLK_DIV(1), .OFFSET_BIN(1)) u_dut2 (
        .clk(clk), .n_reset(n_reset), .audio_in(audio_in), .sample_stb(sample_stb),
        .i2s_bclk(bclk[2]), .i2s_lrclk(lrclk[2]), .i2s_sdata(sdata[2]),
        .frame_start(fstart[2]), .underrun(urun[2]), .overrun(orun[2]));

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int div_of(input int i);
        return (i == 2) ? 1 : 4;
    endfunction

    function automatic int ob_of(input int i);
        return (i == 0) ? 0 : 1;
    endfunction

    function automatic logic [15:0] conv(input logic [15:0] x, input int ob);
        return (ob != 0) ? (x ^ 16'h8000) : x;
    endfunction

    // ------------------------------------------------------------------
    // Reference model: everything follows from t, the number of clk edges
    // since reset release. bclk = (t/D) mod 2; the k-th falling edge is at
    // t = 2*D*k and carries frame bit (k-1) mod 32; bit 0 loads a word.
    // ------------------------------------------------------------------
    int          m_t    [3] = '{default: 0};
    logic [15:0] m_pend [3] = '{default: '0};
    logic        m_pv   [3] = '{default: 1'b0};
    logic [15:0] m_word [3] = '{default: '0};
    logic        e_bclk [3] = '{default: 1'b0};
    logic        e_lr   [3] = '{default: 1'b0};
    logic        e_sd   [3] = '{default: 1'b0};
    logic        e_fs   [3] = '{default: 1'b0};
    logic        e_ur   [3] = '{default: 1'b0};
    logic        e_or   [3] = '{default: 1'b0};

    always @(posedge clk or negedge n_reset) begin
        int          t, n, d;
        logic        fall, load;
        logic [15:0] w;
        if (!n_reset) begin
            for (int i = 0; i < 3; i++) begin
                m_t[i] <= 0;     m_pend[i] <= '0;  m_pv[i] <= 1'b0; m_word[i] <= '0;
                e_bclk[i] <= 1'b0; e_lr[i] <= 1'b0; e_sd[i] <= 1'b0;
                e_fs[i] <= 1'b0;   e_ur[i] <= 1'b0; e_or[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                d    = div_of(i);
                t    = m_t[i] + 1;
                fall = ((t % (2 * d)) == 0);
                n    = fall ? ((t / (2 * d) - 1) % 32) : 0;
                load = fall && (n == 0);
                w    = (load && m_pv[i]) ? conv(m_pend[i], ob_of(i)) : m_word[i];
                m_t[i]    <= t;
                m_word[i] <= w;
                if (sample_stb) begin
                    m_pend[i] <= audio_in;
                    m_pv[i]   <= 1'b1;
                end else if (load) begin
                    m_pv[i]   <= 1'b0;
                end
                e_bclk[i] <= ((t / d) % 2) == 1;
                e_fs[i]   <= load;
                e_ur[i]   <= load && !m_pv[i];
                e_or[i]   <= sample_stb && m_pv[i] && !load;
                if (fall) begin
                    e_sd[i] <= (n < 16) ? w[15 - n] : w[31 - n];
                    e_lr[i] <= (n >= 15) && (n <= 30);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("model[%0d] {bclk,lr,sd,fs,ur,or}", i),
                    {26'd0, bclk[i], lrclk[i], sdata[i], fstart[i], urun[i], orun[i]},
                    {26'd0, e_bclk[i], e_lr[i], e_sd[i], e_fs[i], e_ur[i], e_or[i]});
            end
        end
    end

    // clk edges since reset release, used to place stimulus and checks
    int edge_cnt = 0;
    always @(posedge clk or negedge n_reset) begin
        if (!n_reset) edge_cnt <= 0;
        else          edge_cnt <= edge_cnt + 1;
    end

    task automatic goto(input int k);
        while (edge_cnt < k) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        n_reset = 1'b0;
        repeat (3) @(negedge clk);
        n_reset = 1'b1;
    endtask

    // Strobe sampled by clk edge number e.
    task automatic pulse_stb(input int e, input logic [15:0] val);
        goto(e - 1);
        sample_stb = 1'b1;
        audio_in   = val;
        goto(e);
        sample_stb = 1'b0;
    endtask

    // Deserialise one frame of instances 0 and 1 (CLK_DIV=4) whose load edge is base.
    task automatic collect(input int base,
                           output logic [15:0] l0, output logic [15:0] r0,
                           output logic [15:0] l1, output logic [15:0] r1,
                           output logic [31:0] lp, output logic u0, output logic u1);
        l0 = '0; r0 = '0; l1 = '0; r1 = '0; lp = '0; u0 = 1'b0; u1 = 1'b0;
        for (int j = 0; j < 32; j++) begin
            goto(base + 8 * j);
            if (j == 0) begin u0 = urun[0]; u1 = urun[1]; end
            if (j < 16) begin
                l0 = {l0[14:0], sdata[0]};
                l1 = {l1[14:0], sdata[1]};
            end else begin
                r0 = {r0[14:0], sdata[0]};
                r1 = {r1[14:0], sdata[1]};
            end
            lp[j] = lrclk[0];
        end
    endtask

    typedef struct {
        logic [15:0] audio;
        logic [15:0] exp0;   // transmitted word, OFFSET_BIN=0
        logic [15:0] exp1;   // transmitted word, OFFSET_BIN=1
    } vec_t;

    vec_t vecs [4];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] l0, r0, l1, r1;
        logic [31:0] lp;
        logic        u0, u1;

        vecs[0] = '{audio: 16'h8001, exp0: 16'h8001, exp1: 16'h0001};
        vecs[1] = '{audio: 16'h0000, exp0: 16'h0000, exp1: 16'h8000};
        vecs[2] = '{audio: 16'hFFFF, exp0: 16'hFFFF, exp1: 16'h7FFF};
        vecs[3] = '{audio: 16'h1234, exp0: 16'h1234, exp1: 16'h9234};

        // ---- reset state and idle stream timing ----
        #1 n_reset = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;
        chk("reset outputs", {14'd0, bclk, lrclk, sdata, fstart, urun, orun}, 32'd0);
        repeat (2) @(negedge clk);
        n_reset = 1'b1;
        goto(2);   chk("div1 first frame_start", {31'd0, fstart[2]}, 32'd1);
        goto(3);   chk("bclk before clk4", {31'd0, bclk[0]}, 32'd0);
        goto(4);   chk("bclk rise clk4", {31'd0, bclk[0]}, 32'd1);
        goto(7);   chk("no frame_start clk7", {31'd0, fstart[0]}, 32'd0);
        goto(8);   chk("bclk fall clk8", {31'd0, bclk[0]}, 32'd0);
                   chk("frame_start/underrun clk8", {30'd0, fstart[0], urun[0]}, 32'd3);
        goto(9);   chk("pulse width clk9", {30'd0, fstart[0], urun[0]}, 32'd0);
        goto(264); chk("underrun repeats clk264", {31'd0, urun[0]}, 32'd1);

        // ---- conversion table: one sample before the first frame ----
        for (int v = 0; v < 4; v++) begin
            do_reset();
            pulse_stb(2, vecs[v].audio);
            collect(8, l0, r0, l1, r1, lp, u0, u1);
            chk($sformatf("vec%0d left ob0", v),  {16'd0, l0}, {16'd0, vecs[v].exp0});
            chk($sformatf("vec%0d right ob0", v), {16'd0, r0}, {16'd0, vecs[v].exp0});
            chk($sformatf("vec%0d left ob1", v),  {16'd0, l1}, {16'd0, vecs[v].exp1});
            chk($sformatf("vec%0d right ob1", v), {16'd0, r1}, {16'd0, vecs[v].exp1});
            chk($sformatf("vec%0d lrclk pattern", v), lp, 32'h7FFF_8000);
            chk($sformatf("vec%0d no underrun", v), {30'd0, u0, u1}, 32'd0);
        end

        // ---- two strobes in one frame: overrun, newest sample wins ----
        do_reset();
        pulse_stb(20, 16'h1234);
        chk("first stb no overrun", {31'd0, orun[0]}, 32'd0);
        pulse_stb(40, 16'h5678);
        chk("second stb overrun", {30'd0, orun[0], orun[1]}, 32'd3);
        goto(41);
        chk("overrun one clk", {31'd0, orun[0]}, 32'd0);
        collect(264, l0, r0, l1, r1, lp, u0, u1);
        chk("after overrun left", {16'd0, l0}, 32'h5678);
        chk("after overrun right", {16'd0, r0}, 32'h5678);

        // ---- strobe in the frame-load cycle ----
        do_reset();
        pulse_stb(100, 16'h5555);
        pulse_stb(264, 16'hAAAA);
        chk("load+stb {fs,ur,or}", {29'd0, fstart[0], urun[0], orun[0]}, 32'h4);
        collect(264, l0, r0, l1, r1, lp, u0, u1);
        chk("load+stb old word", {16'd0, l0}, 32'h5555);
        collect(520, l0, r0, l1, r1, lp, u0, u1);
        chk("load+stb new word", {16'd0, l0}, 32'hAAAA);
        chk("load+stb next no underrun", {31'd0, u0}, 32'd0);

        // ---- asynchronous reset mid-frame (bit_cnt 20) ----
        do_reset();
        pulse_stb(50, 16'hFFFF);
        goto(170);
        #2 n_reset = 1'b0;
        #1 chk("async reset outputs", {14'd0, bclk, lrclk, sdata, fstart, urun, orun}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        n_reset = 1'b1;
        goto(7);
        chk("restart no early frame", {31'd0, fstart[0]}, 32'd0);
        goto(8);
        chk("restart frame_start clk8", {31'd0, fstart[0]}, 32'd1);
        collect(8, l0, r0, l1, r1, lp, u0, u1);
        chk("restart underrun", {31'd0, u0}, 32'd1);
        chk("restart word zero", {l0, r0}, 32'd0);

        // ---- randomized traffic checked by the model only ----
        do_reset();
        for (int c = 0; c < 6000; c++) begin
            @(negedge clk);
            sample_stb = ($urandom_range(0, 199) == 0);
            audio_in   = 16'($urandom);
        end
        @(negedge clk);
        sample_stb = 1'b0;
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
